// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory stage that sits directly after the ALU. One load or store is performed
// per instruction over a req/gnt/rvalid data-memory bus. The unit builds byte
// enables and lane-replicated store data, extends load data, rejects illegal or
// misaligned operations without touching the bus, and aborts bus accesses that
// do not complete within TIMEOUT_CYCLES.
//
// Handshakes:
//   core side : req_valid is raised with the op and held stable until
//               resp_valid. The op is taken only while req_ready (IDLE) is high.
//               resp_valid is a one-cycle pulse; stall = req_valid & ~resp_valid.
//   bus side  : mem_req is held high with mem_addr/mem_we/mem_wdata/mem_be
//               stable until the cycle mem_gnt is seen. The response
//               (mem_rvalid, plus mem_rdata for loads) is accepted only in
//               WAIT, i.e. at least one cycle after the grant.
//
// Ports:
//   clk, reset                       clock (rising edge), async active-high reset
//   req_valid, req_is_store,
//   req_funct3, req_addr, req_wdata  operation from the core
//   req_ready                        unit is idle and can accept an op
//   stall                            core holds PC while high
//   resp_valid, resp_rdata,
//   resp_error                       completion pulse, extended load data, error
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be                bus request
//   mem_gnt, mem_rvalid, mem_rdata   bus grant and response
//
// The FSM state is held in the signal "state" so checkers can bind to it.
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Timer value seen during the last permitted REQ/WAIT cycle.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  timer;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [1:0]  op_lane;

  // ---------------------------------------------------------------------------
  // Request decode (combinational, used only on the IDLE accept edge)
  // funct3[1:0] encodes the size: 00 byte, 01 half, 10 word.
  // ---------------------------------------------------------------------------
  logic [1:0]  req_size;
  logic [1:0]  req_lane;
  logic        f3_legal;
  logic        misaligned;
  logic        req_ok;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  assign req_size = req_funct3[1:0];
  assign req_lane = req_addr[1:0];

  always_comb begin
    if (req_is_store) begin
      f3_legal = ~req_funct3[2] & (req_size != 2'b11);
    end else begin
      f3_legal = (req_size != 2'b11) & (req_funct3 != 3'b110);
    end
  end

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_lane[0];
      2'b10:   misaligned = (req_lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign req_ok = f3_legal & ~misaligned;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = req_wdata;
    case (req_size)
      2'b00: begin
        be_c    = 4'b0001 << req_lane;
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << req_lane;
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = req_wdata;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load data extraction from the latched op. Half accesses are aligned, so
  // only lanes 0 and 2 can occur and op_lane[1] selects the half-word.
  // ---------------------------------------------------------------------------
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  assign rd_byte = mem_rdata[{op_lane, 3'b000} +: 8];
  assign rd_half = mem_rdata[{op_lane[1], 4'b0000} +: 16];

  always_comb begin
    case (op_funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'h000000, rd_byte};
      3'b101:  load_data = {16'h0000, rd_half};
      default: load_data = mem_rdata;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign stall     = req_valid & ~resp_valid;

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= 8'd0;
      op_store   <= 1'b0;
      op_funct3  <= 3'd0;
      op_lane    <= 2'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_be     <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_ok) begin
              state     <= REQ;
              timer     <= 8'd0;
              op_store  <= req_is_store;
              op_funct3 <= req_funct3;
              op_lane   <= req_lane;
              mem_req   <= 1'b1;
              mem_we    <= req_is_store;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be_c;
              mem_wdata <= req_is_store ? wdata_c : 32'd0;
            end else begin
              // Rejected without any bus activity.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'd0;
            end
          end
        end

        REQ: begin
          timer <= timer + 8'd1;
          // A response arriving together with the grant is not accepted
          // here; only WAIT looks at mem_rvalid.
          if (timer == TIMER_LAST) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= 32'd0;
          end else if (mem_gnt) begin
            state   <= WAIT;
            mem_req <= 1'b0;
          end
        end

        WAIT: begin
          timer <= timer + 8'd1;
          if (mem_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= op_store ? 32'd0 : load_data;
          end else if (timer == TIMER_LAST) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= 32'd0;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
